gate_tt_sequencer: RTL and testbench

// - Self-checking controller for one combinational gate under test (NAND, AND, XOR, ...).
// - Drives every input combination onto the gate in order and samples the gate output.
// - Compares each sample with a parameterised expected truth table.
// - Reports pass/fail, mismatch count and first failing vector.
// - Sits between a simple start/done host and the gate instance; replaces hand-written stimulus.

---
 rtl/gate_tt_sequencer.sv | 100 ++++++++++
 tb/tb_gate_tt_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/gate_tt_sequencer.sv
// rtl/gate_tt_sequencer.sv - truth-table sweep controller for one gate under test (optional TT_CAPTURE_EN)
module gate_tt_sequencer #(
    parameter int                N_IN       = 2,
    parameter int                SETTLE_CYC = 2,
    parameter logic [2**N_IN-1:0] EXPECT    = 4'b0111
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 gate_out,
    output logic [N_IN-1:0]      gate_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_cnt,
`ifdef TT_CAPTURE_EN
    output logic [2**N_IN-1:0]   tt_captured,
`endif
    output logic [N_IN-1:0]      fail_idx
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [N_IN-1:0] LAST_IDX = '1;
    localparam logic [3:0]      SETTLE   = 4'(SETTLE_CYC);

    state_t          state;
    logic [N_IN-1:0] idx;
    logic [3:0]      wait_cnt;
    logic            mismatch;
    logic [N_IN:0]   err_next;

    // err_next folds in the sample taken on this edge so pass reflects the final vector
    assign mismatch = (gate_out != EXPECT[idx]);
    assign err_next = err_cnt + {{N_IN{1'b0}}, mismatch};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            wait_cnt    <= '0;
            gate_in     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_cnt     <= '0;
            fail_idx    <= '0;
`ifdef TT_CAPTURE_EN
            tt_captured <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RUN;
                        idx         <= '0;
                        gate_in     <= '0;
                        wait_cnt    <= '0;
                        busy        <= 1'b1;
                        pass        <= 1'b0;
                        err_cnt     <= '0;
                        fail_idx    <= '0;
`ifdef TT_CAPTURE_EN
                        tt_captured <= '0;
`endif
                    end
                end
                RUN: begin
                    if (wait_cnt < SETTLE) begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end else begin
                        err_cnt <= err_next;
                        if (mismatch && (err_cnt == '0))
                            fail_idx <= idx;
`ifdef TT_CAPTURE_EN
                        tt_captured[idx] <= gate_out;
`endif
                        if (idx != LAST_IDX) begin
                            idx      <= idx + 1'b1;
                            gate_in  <= idx + 1'b1;
                            wait_cnt <= '0;
                        end else begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            pass     <= (err_next == '0);
                            wait_cnt <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// tb/tb_gate_tt_sequencer.sv - directed self-checking bench for gate_tt_sequencer
module tb_gate_tt_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start_a = 1'b0;
    logic       go_a;
    logic [1:0] gi_a;
    logic       busy_a, done_a, pass_a;
    logic [2:0] err_a;
    logic [1:0] fidx_a;
    int         sel = 0;

    logic       start_b = 1'b0;
    logic       go_b;
    logic [0:0] gi_b;
    logic       busy_b, done_b, pass_b;
    logic [1:0] err_b;
    logic [0:0] fidx_b;

`ifdef TT_CAPTURE_EN
    logic [3:0] cap_a;
    logic [1:0] cap_b;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // 0 NAND, 1 AND, 2 NAND stuck-at-1, 3 XOR
    always_comb begin
        case (sel)
            0:       go_a = ~(gi_a[1] & gi_a[0]);
            1:       go_a = gi_a[1] & gi_a[0];
            2:       go_a = 1'b1;
            default: go_a = gi_a[1] ^ gi_a[0];
        endcase
    end
    assign go_b = ~gi_b[0];

    gate_tt_sequencer #(.N_IN(2), .SETTLE_CYC(2), .EXPECT(4'b0111)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .gate_out(go_a),
        .gate_in(gi_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_cnt(err_a),
`ifdef TT_CAPTURE_EN
        .tt_captured(cap_a),
`endif
        .fail_idx(fidx_a)
    );

    gate_tt_sequencer #(.N_IN(1), .SETTLE_CYC(0), .EXPECT(2'b01)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .gate_out(go_b),
        .gate_in(gi_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_cnt(err_b),
`ifdef TT_CAPTURE_EN
        .tt_captured(cap_b),
`endif
        .fail_idx(fidx_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
        end
    endtask

    // lat = cycles from the start edge until done is seen; hold_err counts gate_in deviations
    task automatic sweep_a(input int model, output int lat, output int hold_err);
        sel = model;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        lat = 0;
        hold_err = 0;
        while (!done_a && lat < 200) begin
            if (int'(gi_a) != lat / 3) hold_err++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, herr, dcount;

        repeat (3) @(negedge clk);
        check("rst_gate_in", gi_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_pass", pass_a, 0);
        check("rst_err", err_a, 0);
        check("rst_fidx", fidx_a, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // NAND matches the table
        sweep_a(0, lat, herr);
        check("nand_lat", lat, 12);
        check("nand_hold", herr, 0);
        check("nand_pass", pass_a, 1);
        check("nand_err", err_a, 0);
        @(negedge clk);
        check("nand_done_pulse", done_a, 0);
        check("nand_busy_after", busy_a, 0);
        check("nand_pass_held", pass_a, 1);

        // AND mismatches every vector
        sweep_a(1, lat, herr);
        check("and_lat", lat, 12);
        check("and_err", err_a, 4);
        check("and_fidx", fidx_a, 0);
        check("and_pass", pass_a, 0);

        // only vector 3 (1,1) differs when stuck at 1
        sweep_a(2, lat, herr);
        check("stuck_err", err_a, 1);
        check("stuck_fidx", fidx_a, 3);
        check("stuck_pass", pass_a, 0);

        // XOR vs NAND table: only vector 0 differs
        sweep_a(3, lat, herr);
        check("xor_err", err_a, 1);
        check("xor_fidx", fidx_a, 0);
        check("xor_pass", pass_a, 0);
`ifdef TT_CAPTURE_EN
        check("xor_cap", cap_a, 4'b0110);
        sweep_a(0, lat, herr);
        check("nand_cap", cap_a, 4'b0111);
`endif

        // start pulses during RUN are ignored, then reset abandons the sweep
        sel = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 7) begin
                check("ign_gate_in", gi_a, 2);
                check("ign_busy", busy_a, 1);
            end
            start_a = (k == 3 || k == 6);
            if (k == 8) rst_n = 1'b0;
        end
        @(negedge clk);
        check("mid_rst_gate_in", gi_a, 0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_done", done_a, 0);
        rst_n = 1'b1;
        dcount = 0;
        repeat (15) begin
            @(negedge clk);
            if (done_a) dcount++;
        end
        check("mid_rst_no_done", dcount, 0);
        sweep_a(0, lat, herr);
        check("post_rst_lat", lat, 12);
        check("post_rst_pass", pass_a, 1);

        // N_IN=1 SETTLE_CYC=0 inverter, start held through done
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        lat = 0;
        while (!done_b && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("inv_lat", lat, 2);
        check("inv_pass", pass_b, 1);
        check("inv_err", err_b, 0);
        @(negedge clk);
        check("inv_restart_busy", busy_b, 1);
        check("inv_restart_pass", pass_b, 0);
        lat = 0;
        while (!done_b && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("inv_lat2", lat, 2);
        check("inv_pass2", pass_b, 1);
`ifdef TT_CAPTURE_EN
        check("inv_cap", cap_b, 2'b01);
`endif
        start_b = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
